// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and line-level constants for the UART TX framer.
//   state_t   - framer FSM states (BRK only reachable with UART_TX_FRAME_BREAK_EN)
//   PAR_*     - parity type encodings for PAR_TYP
//   *_BIT     - line levels for idle, start and stop
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRK
    } state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: request/config/line bundle between the upstream producer
// and the UART TX framer.
//   master - drives P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2 (and BREAK when
//            UART_TX_FRAME_BREAK_EN is defined); observes TX_OUT, BUSY
//   slave  - the framer side
interface uart_tx_frame_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
`ifdef UART_TX_FRAME_BREAK_EN
    logic                  BREAK;
`endif
    logic                  TX_OUT;
    logic                  BUSY;

    modport master (
`ifdef UART_TX_FRAME_BREAK_EN
        output BREAK,
`endif
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
        input  TX_OUT, BUSY
    );

    modport slave (
`ifdef UART_TX_FRAME_BREAK_EN
        input  BREAK,
`endif
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
        output TX_OUT, BUSY
    );

endinterface : uart_tx_frame_if

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: data shift register and data-bit counter.
//   i_load    - latch i_data into the shift register
//   i_clr     - clear the bit counter (entry into the data phase)
//   i_shift   - advance one bit; counter saturates at DATA_WIDTH-1
//   o_bit     - current LSB of the shift register
//   o_done_c  - counter has reached the last data bit
module uart_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_clr,
    input  logic                  i_shift,
    output logic                  o_bit,
    output logic                  o_done_c
);

    localparam int unsigned     CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    // Data register: load wins, otherwise shift LSB-first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
        end
    end

    // Bit counter: index of the data bit currently on the line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_shift && (r_cnt != CNT_LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_bit    = r_shift[0];
    assign o_done_c = (r_cnt == CNT_LAST);

endmodule : uart_tx_serializer

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: self-sequencing UART transmit framer, one bit per CLK.
// Frame = start, DATA_WIDTH data bits LSB-first, optional parity, 1 or 2 stops.
//   CLK  - baud-rate clock
//   RST  - asynchronous active-low reset
//   bus  - uart_tx_frame_if slave: P_DATA/DATA_VALID/PAR_EN/PAR_TYP/STOP2 in,
//          TX_OUT/BUSY out (both registered)
// Optional feature macro UART_TX_FRAME_BREAK_EN adds a BREAK input that holds
// the line low from IDLE or the final stop cycle.
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic         CLK,
    input  logic         RST,
    uart_tx_frame_if.slave bus
);

    state_t r_state;
    logic   r_tx;
    logic   r_busy;
    logic   r_par_en;
    logic   r_stop2;
    logic   r_parity;

    logic   w_brk;
    logic   w_accept;
    logic   w_bit;
    logic   w_done;
    logic   w_clr;
    logic   w_shift;

`ifdef UART_TX_FRAME_BREAK_EN
    assign w_brk = bus.BREAK;
`else
    assign w_brk = 1'b0;
`endif

    // BUSY is low only in IDLE and the final stop cycle, so this is the full
    // accept condition; break takes priority over a request.
    assign w_accept = bus.DATA_VALID && !r_busy && !w_brk;
    assign w_clr    = (r_state == START);
    assign w_shift  = (r_state == START) || ((r_state == DATA) && !w_done);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_load   (w_accept),
        .i_data   (bus.P_DATA),
        .i_clr    (w_clr),
        .i_shift  (w_shift),
        .o_bit    (w_bit),
        .o_done_c (w_done)
    );

    // Framer FSM; r_tx is loaded with the level of the state being entered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_tx     <= LINE_IDLE;
            r_busy   <= 1'b0;
            r_par_en <= 1'b0;
            r_stop2  <= 1'b0;
            r_parity <= 1'b0;
        end else begin
            case (r_state)
                IDLE, STOP1, STOP2: begin
                    if ((r_state == STOP1) && r_stop2) begin
                        // Entering the last stop bit: release BUSY now.
                        r_state <= STOP2;
                        r_tx    <= STOP_BIT;
                        r_busy  <= 1'b0;
                    end else if (w_brk) begin
                        r_state <= BRK;
                        r_tx    <= START_BIT;
                        r_busy  <= 1'b1;
                    end else if (w_accept) begin
                        r_state  <= START;
                        r_tx     <= START_BIT;
                        r_busy   <= 1'b1;
                        r_par_en <= bus.PAR_EN;
                        r_stop2  <= bus.STOP2;
                        r_parity <= (^bus.P_DATA) ^ (bus.PAR_TYP == PAR_ODD);
                    end else begin
                        r_state <= IDLE;
                        r_tx    <= LINE_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                START: begin
                    r_state <= DATA;
                    r_tx    <= w_bit;
                end
                DATA: begin
                    if (!w_done) begin
                        r_tx <= w_bit;
                    end else if (r_par_en) begin
                        r_state <= PARITY;
                        r_tx    <= r_parity;
                    end else begin
                        r_state <= STOP1;
                        r_tx    <= STOP_BIT;
                        r_busy  <= r_stop2;
                    end
                end
                PARITY: begin
                    r_state <= STOP1;
                    r_tx    <= STOP_BIT;
                    r_busy  <= r_stop2;
                end
                BRK: begin
                    // Return through IDLE so the line shows a mark first.
                    if (!w_brk) begin
                        r_state <= IDLE;
                        r_tx    <= LINE_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= LINE_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TX_OUT = r_tx;
    assign bus.BUSY   = r_busy;

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed, table-driven bench for uart_tx_frame (8-bit).
// Builds with or without UART_TX_FRAME_BREAK_EN.
module tb_uart_tx_frame;

    logic CLK;
    logic RST;

    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected line pattern: bits[i] is TX_OUT in frame cycle i.
    typedef struct {
        string      name;
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       s2;
        int         len;
        logic [11:0] bits;
    } rec_t;

    rec_t tbl [6];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive_req(input rec_t r);
        bus.P_DATA     = r.data;
        bus.PAR_EN     = r.pe;
        bus.PAR_TYP    = r.pt;
        bus.STOP2      = r.s2;
        bus.DATA_VALID = 1'b1;
    endtask

    // Called at the negedge inside frame cycle 0; returns at the negedge of
    // cycle ncyc-1. Unless keep is set, scrambles the inputs after accept and
    // pulses DATA_VALID mid-frame (must be dropped).
    task automatic check_frame(input rec_t r, input bit keep, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge CLK);
            chk($sformatf("%s tx c%0d", r.name, i), bus.TX_OUT, r.bits[i]);
            chk($sformatf("%s busy c%0d", r.name, i), bus.BUSY,
                (i == r.len - 1) ? 1'b0 : 1'b1);
            if (!keep) begin
                if (i == 0) begin
                    bus.DATA_VALID = 1'b0;
                    bus.P_DATA     = ~r.data;
                    bus.PAR_EN     = ~r.pe;
                    bus.PAR_TYP    = ~r.pt;
                    bus.STOP2      = ~r.s2;
                end else if (i == 3) begin
                    bus.DATA_VALID = 1'b1;
                end else if (i == 4) begin
                    bus.DATA_VALID = 1'b0;
                end
            end
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, " idle tx"}, bus.TX_OUT, 1'b1);
        chk({name, " idle busy"}, bus.BUSY, 1'b0);
    endtask

    initial begin
        tbl[0] = '{"a5_even",  8'hA5, 1'b1, 1'b0, 1'b0, 11, 12'b0_10101001010};
        tbl[1] = '{"01_odd",   8'h01, 1'b1, 1'b1, 1'b0, 11, 12'b0_10000000010};
        tbl[2] = '{"01_even",  8'h01, 1'b1, 1'b0, 1'b0, 11, 12'b0_11000000010};
        tbl[3] = '{"ff_2stop", 8'hFF, 1'b0, 1'b0, 1'b1, 11, 12'b0_11111111110};
        tbl[4] = '{"00_plain", 8'h00, 1'b0, 1'b0, 1'b0, 10, 12'b00_1000000000};
        tbl[5] = '{"3c_odd_2", 8'h3C, 1'b1, 1'b1, 1'b1, 12, 12'b111001111000};

        RST            = 1'b0;
        bus.P_DATA     = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.STOP2      = 1'b0;
`ifdef UART_TX_FRAME_BREAK_EN
        bus.BREAK      = 1'b0;
`endif
        #12;
        check_idle("reset");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_idle("post_reset");

        // Table: one isolated frame per record, then an idle check.
        for (int k = 0; k < 6; k++) begin
            drive_req(tbl[k]);
            @(posedge CLK);
            @(negedge CLK);
            check_frame(tbl[k], 1'b0, tbl[k].len);
            @(negedge CLK);
            check_idle(tbl[k].name);
        end

        // Back-to-back: DATA_VALID held high across two frames.
        drive_req(tbl[4]);
        @(posedge CLK);
        @(negedge CLK);
        drive_req(tbl[5]);
        check_frame(tbl[4], 1'b1, tbl[4].len);
        @(negedge CLK);
        check_frame(tbl[5], 1'b0, tbl[5].len);
        @(negedge CLK);
        check_idle("b2b");

        // Reset during the 5th data bit (frame cycle 5).
        drive_req(tbl[0]);
        @(posedge CLK);
        @(negedge CLK);
        check_frame(tbl[0], 1'b0, 6);
        #2 RST = 1'b0;
        #1;
        check_idle("mid_reset");
        @(negedge CLK);
        check_idle("held_reset");
        bus.DATA_VALID = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        check_idle("after_release");
        drive_req(tbl[3]);
        @(posedge CLK);
        @(negedge CLK);
        check_frame(tbl[3], 1'b0, tbl[3].len);
        @(negedge CLK);
        check_idle("clean_after_reset");

`ifdef UART_TX_FRAME_BREAK_EN
        // Break with a pending request: line low 20 cycles, mark, then frame.
        drive_req(tbl[0]);
        bus.BREAK = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk($sformatf("brk tx c%0d", i), bus.TX_OUT, 1'b0);
            chk($sformatf("brk busy c%0d", i), bus.BUSY, 1'b1);
        end
        bus.BREAK = 1'b0;
        @(negedge CLK);
        check_idle("brk_mark");
        @(negedge CLK);
        check_frame(tbl[0], 1'b0, tbl[0].len);
        @(negedge CLK);
        check_idle("brk_frame");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_frame
